calc_sequencer: RTL and testbench

Multi-cycle arithmetic sequencer for the calculator datapath. It accepts a start request with two signed operands and an add/sub selector from the keypad operation FSM. It runs a bit-serial add/subtract over WIDTH cycles and returns the result with a done pulse and an overflow flag. It also owns the single memory register, arbitrating between keypad SAVE requests and automatic result write-back.

---
 rtl/calc_pkg.sv | 18 +
 rtl/serial_full_adder.sv | 13 +
 rtl/calc_sequencer.sv | 131 +++++++++++++
 tb/tb_calc_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator arithmetic sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } calc_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CALC_WIDTH = 8;

  localparam logic [CALC_WIDTH-1:0] CALC_SAT_MAX = {1'b0, {(CALC_WIDTH-1){1'b1}}};
  localparam logic [CALC_WIDTH-1:0] CALC_SAT_MIN = {1'b1, {(CALC_WIDTH-1){1'b0}}};

endpackage

// File: rtl/serial_full_adder.sv
// Combinational 1-bit full adder used by the bit-serial datapath.
module serial_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/calc_sequencer.sv
// Bit-serial add/subtract sequencer owning the calculator memory register.
// Optional CALC_SATURATE_EN clamps overflowing results to the signed limits.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic             operation,
  input  logic [WIDTH-1:0] numberA,
  input  logic [WIDTH-1:0] numberB,
  input  logic             autoStore,
  input  logic             saveReq,
  input  logic [WIDTH-1:0] saveData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             saveAck,
  output logic [WIDTH-1:0] memoryOut,
  output calc_state_t      stateDbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  calc_state_t r_state, w_next_state;

  logic [WIDTH-1:0] r_a, r_b, r_sum, r_result, r_mem;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_auto, r_ovf, r_save_ack;

  logic             w_sum, w_cout, w_last, w_ovf, w_wb, w_save;
  logic [WIDTH-1:0] w_raw, w_final;

  serial_full_adder u_fa (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  assign w_last = (r_cnt == LAST_BIT);
  assign w_raw  = {w_sum, r_sum[WIDTH-1:1]};
  assign w_ovf  = r_carry ^ w_cout;

`ifdef CALC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // On the final bit r_a[0] is the sign of operand A.
  assign w_final = w_ovf ? (r_a[0] ? SAT_MIN : SAT_MAX) : w_raw;
`else
  assign w_final = w_raw;
`endif

  // Write-back has priority; a save is acked at most once per request.
  assign w_wb   = (r_state == DONE) && r_auto;
  assign w_save = saveReq && !w_wb && !r_save_ack;

  always_ff @(posedge Clock) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_result   <= '0;
      r_mem      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_auto     <= 1'b0;
      r_ovf      <= 1'b0;
      r_save_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= numberA;
            r_b     <= (operation == OP_SUB) ? ~numberB : numberB;
            r_carry <= operation;
            r_cnt   <= '0;
            r_auto  <= autoStore;
          end
        end
        SHIFT: begin
          r_sum   <= w_raw;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_final;
            r_ovf    <= w_ovf;
          end
        end
        default: ;
      endcase
      if (w_wb)        r_mem <= r_result;
      else if (w_save) r_mem <= saveData;
      r_save_ack <= w_save;
    end
  end

  assign result    = r_result;
  assign overflow  = r_ovf;
  assign saveAck   = r_save_ack;
  assign memoryOut = r_mem;
  assign stateDbg  = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W = CALC_WIDTH;

  logic         clk = 1'b0;
  logic         clear, start, operation, autoStore, saveReq;
  logic [W-1:0] numberA, numberB, saveData;
  logic         busy, done, overflow, saveAck;
  logic [W-1:0] result, memoryOut;
  calc_state_t  stateDbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_mem;

  calc_sequencer dut (
    .Clock(clk), .clear(clear), .start(start), .operation(operation),
    .numberA(numberA), .numberB(numberB), .autoStore(autoStore),
    .saveReq(saveReq), .saveData(saveData), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .saveAck(saveAck),
    .memoryOut(memoryOut), .stateDbg(stateDbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start at edge 0, then walk cycles 1..W+1 checking busy/done timing.
  task automatic run_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          input logic auto_st, input logic [W-1:0] exp_res,
                          input logic exp_ovf, input logic poke_start,
                          input logic save_at_done);
    logic [W-1:0] got_exp;
    numberA = a; numberB = b; operation = op; autoStore = auto_st; start = 1'b1;
    exp_q.push_back(exp_res);
    tick();
    start = 1'b0;
    numberA = W'($urandom_range(0, 255));
    numberB = W'($urandom_range(0, 255));
    operation = 1'($urandom_range(0, 1));
    autoStore = 1'b0;
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      check($sformatf("busy_c%0d", cyc), busy, 1'b1);
      check($sformatf("done_c%0d", cyc), done, (cyc == W + 1));
      if (cyc == 3 && poke_start) begin
        start = 1'b1; autoStore = 1'b1; numberA = 8'h10; numberB = 8'h10;
      end else begin
        start = 1'b0; autoStore = 1'b0;
      end
      if (cyc == W + 1) begin
        got_exp = exp_q.pop_front();
        check("result", result, got_exp);
        check("overflow", overflow, exp_ovf);
        if (save_at_done) begin
          saveReq = 1'b1; saveData = 8'h33;
        end
      end
      tick();
    end
    check("busy_after", busy, 1'b0);
    check("done_after", done, 1'b0);
    if (auto_st) exp_mem = exp_res;
    check("mem_after", memoryOut, exp_mem);
  endtask

  task automatic watch_no_done(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; operation = OP_ADD; autoStore = 1'b0;
    saveReq = 1'b0; numberA = '0; numberB = '0; saveData = '0; exp_mem = '0;
    tick(); tick();
    clear = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ack", saveAck, 0);
    check("rst_result", result, 0);
    check("rst_mem", memoryOut, 0);
    check("rst_state", stateDbg, IDLE);
    tick();

    run_calc(8'h05, 8'h03, OP_ADD, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    run_calc(8'h03, 8'h05, OP_SUB, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
`ifdef CALC_SATURATE_EN
    run_calc(8'h80, 8'h01, OP_SUB, 1'b0, CALC_SAT_MIN, 1'b1, 1'b0, 1'b0);
    run_calc(8'h64, 8'h64, OP_ADD, 1'b0, CALC_SAT_MAX, 1'b1, 1'b0, 1'b0);
`else
    run_calc(8'h80, 8'h01, OP_SUB, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0);
    run_calc(8'h64, 8'h64, OP_ADD, 1'b0, 8'hC8, 1'b1, 1'b0, 1'b0);
`endif
    check("ovf_held", overflow, 1'b1);

    // Plain save in IDLE: ack and data visible the next cycle.
    saveReq = 1'b1; saveData = 8'h5A;
    tick();
    exp_mem = 8'h5A;
    check("save_ack", saveAck, 1'b1);
    check("save_mem", memoryOut, 8'h5A);
    saveReq = 1'b0;
    tick();
    check("save_ack_drop", saveAck, 1'b0);

    // Write-back vs save on the same edge: write-back first, save one edge later.
    run_calc(8'h02, 8'h02, OP_ADD, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
    check("arb_ack0", saveAck, 1'b0);
    tick();
    exp_mem = 8'h33;
    check("arb_ack1", saveAck, 1'b1);
    check("arb_mem", memoryOut, 8'h33);
    tick();
    saveReq = 1'b0;
    check("arb_ack_once", saveAck, 1'b0);
    check("arb_mem_hold", memoryOut, 8'h33);
    tick();

    // Abort with clear in cycle 4.
    numberA = 8'h11; numberB = 8'h22; operation = OP_ADD; autoStore = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; autoStore = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_c4", busy, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_mem = '0;
    check("abort_busy", busy, 1'b0);
    check("abort_state", stateDbg, IDLE);
    check("abort_mem", memoryOut, 8'h00);
    watch_no_done(12, "abort_no_done");

    run_calc(8'h7F, 8'h01, OP_SUB, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0);

    // start pulsed while busy must not produce a second calculation.
    run_calc(8'hF0, 8'h20, OP_ADD, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
    watch_no_done(12, "ignored_start");
    check("ignored_mem", memoryOut, exp_mem);
    check("ignored_result", result, 8'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
